div_unit: RTL and testbench

Iterative radix-2 divide/remainder unit for the RV32M DIV, DIVU, REM and REMU operations. It sits in the EX stage beside the combinational ALU and replaces the ALU's single-cycle divide path. It takes the same operands and control code the ALU receives. Its result feeds the EX/MEM register through the EX result mux, and oBusy drives the pipeline stall logic.

---
 rtl/div_unit.sv | 140 ++++++++++++++
 tb/tb_div_unit.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divide/remainder for RV32M DIV/DIVU/REM/REMU; 33-cycle normal, 1-cycle special-case latency.
// Backpressure: oBusy stalls the pipe; iStart only sampled in IDLE. Optional DIV_EARLY_OUT_EN: |A|<|B| completes on the fast path.
module div_unit #(
    parameter int XLEN = 32
) (
    input  logic            iCLK,
    input  logic            iRST,
    input  logic            iStart,
    input  logic [4:0]      iControl,
    input  logic [XLEN-1:0] iA,
    input  logic [XLEN-1:0] iB,
    output logic            oBusy,
    output logic            oReady,
    output logic [XLEN-1:0] oResult
);

    localparam logic [4:0] OPDIV  = 5'd13;
    localparam logic [4:0] OPDIVU = 5'd14;
    localparam logic [4:0] OPREM  = 5'd15;
    localparam logic [4:0] OPREMU = 5'd16;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]        state;
    logic [5:0]        cnt;
    logic [2*XLEN-1:0] rq;
    logic [XLEN-1:0]   dvsr;
    logic              op_div;
    logic              q_neg;
    logic              r_neg;
    logic              spec;

    // request decode and special-case result, evaluated at accept
    logic            is_div, is_rem, is_sgn, valid;
    logic            a_neg, b_neg, b_zero, ovf, early, special;
    logic [XLEN-1:0] mag_a, mag_b, spec_res;

    always_comb begin
        is_div  = (iControl == OPDIV) || (iControl == OPDIVU);
        is_rem  = (iControl == OPREM) || (iControl == OPREMU);
        is_sgn  = (iControl == OPDIV) || (iControl == OPREM);
        valid   = is_div || is_rem;
        a_neg   = is_sgn && iA[XLEN-1];
        b_neg   = is_sgn && iB[XLEN-1];
        mag_a   = a_neg ? -iA : iA;
        mag_b   = b_neg ? -iB : iB;
        b_zero  = (iB == '0);
        ovf     = is_sgn && (iA == 32'h8000_0000) && (iB == 32'hFFFF_FFFF);
`ifdef DIV_EARLY_OUT_EN
        early   = valid && !b_zero && (mag_a < mag_b);
`else
        early   = 1'b0;
`endif
        special = !valid || b_zero || ovf || early;
        if (!valid)
            spec_res = '0;
        else if (b_zero)
            spec_res = is_div ? 32'hFFFF_FFFF : iA;
        else if (ovf)
            spec_res = is_div ? 32'h8000_0000 : '0;
        else
            spec_res = is_div ? '0 : iA;
    end

    // one restoring step: shift, trial-subtract from upper 33 bits
    logic [2*XLEN:0]   sh;
    logic [XLEN:0]     upper;
    logic [XLEN-1:0]   diff;
    logic [2*XLEN-1:0] next_rq;

    always_comb begin
        sh    = {rq, 1'b0};
        upper = sh[2*XLEN:XLEN];
        diff  = upper[XLEN-1:0] - dvsr;
        if (upper >= {1'b0, dvsr})
            next_rq = {diff, sh[XLEN-1:1], 1'b1};
        else
            next_rq = sh[2*XLEN-1:0];
    end

    logic [XLEN-1:0] quo, rem, fin_res;

    always_comb begin
        quo = rq[XLEN-1:0];
        rem = rq[2*XLEN-1:XLEN];
        if (spec)
            fin_res = rq[XLEN-1:0];
        else if (op_div)
            fin_res = q_neg ? -quo : quo;
        else
            fin_res = r_neg ? -rem : rem;
    end

    always_ff @(posedge iCLK) begin
        if (!iRST) begin
            state   <= IDLE;
            cnt     <= '0;
            rq      <= '0;
            dvsr    <= '0;
            op_div  <= 1'b0;
            q_neg   <= 1'b0;
            r_neg   <= 1'b0;
            spec    <= 1'b0;
            oResult <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (iStart) begin
                        state  <= CALC;
                        op_div <= is_div;
                        q_neg  <= a_neg ^ b_neg;
                        r_neg  <= a_neg;
                        dvsr   <= mag_b;
                        spec   <= special;
                        // special cases skip the iterations and carry their result in rq
                        cnt    <= special ? 6'd32 : 6'd0;
                        rq     <= special ? {{XLEN{1'b0}}, spec_res} : {{XLEN{1'b0}}, mag_a};
                    end
                end
                CALC: begin
                    if (cnt == 6'd32) begin
                        oResult <= fin_res;
                        state   <= DONE;
                    end else begin
                        rq  <= next_rq;
                        cnt <= cnt + 6'd1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign oBusy  = (state == CALC);
    assign oReady = (state == DONE);

endmodule

// File: tb/tb_div_unit.sv
// Directed plus randomized checks of div_unit against a plain-arithmetic RV32M divide model.
module tb_div_unit;

    localparam logic [4:0] OPDIV  = 5'd13;
    localparam logic [4:0] OPDIVU = 5'd14;
    localparam logic [4:0] OPREM  = 5'd15;
    localparam logic [4:0] OPREMU = 5'd16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  ctl = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, ready;
    logic [31:0] result;

    int ncmp  = 0;
    int nfail = 0;
    logic [31:0] last_exp = '0;

    div_unit #(.XLEN(32)) dut (
        .iCLK(clk), .iRST(rst), .iStart(start), .iControl(ctl),
        .iA(a), .iB(b), .oBusy(busy), .oReady(ready), .oResult(result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [4:0] c, input logic [31:0] x, input logic [31:0] y);
        int sx, sy;
        sx = x;
        sy = y;
        case (c)
            OPDIVU: return (y == 0) ? 32'hFFFF_FFFF : x / y;
            OPREMU: return (y == 0) ? x : x % y;
            OPDIV: begin
                if (y == 0) return 32'hFFFF_FFFF;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
                return sx / sy;
            end
            OPREM: begin
                if (y == 0) return x;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h0;
                return sx % sy;
            end
            default: return 32'h0;
        endcase
    endfunction

    function automatic int model_lat(input logic [4:0] c, input logic [31:0] x, input logic [31:0] y);
        bit     sgn, vld;
        longint mx, my;
        vld = (c == OPDIV) || (c == OPDIVU) || (c == OPREM) || (c == OPREMU);
        sgn = (c == OPDIV) || (c == OPREM);
        if (!vld || y == 0) return 1;
        if (sgn && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
        mx = sgn ? longint'($signed(x)) : longint'(x);
        my = sgn ? longint'($signed(y)) : longint'(y);
        if (mx < 0) mx = -mx;
        if (my < 0) my = -my;
`ifdef DIV_EARLY_OUT_EN
        if (mx < my) return 1;
`endif
        return 33;
    endfunction

    // issue one request; optionally poke a conflicting iStart at cycle 'poke' of the operation
    task automatic run_op(input string tag, input logic [4:0] c, input logic [31:0] x,
                          input logic [31:0] y, input int poke);
        int  n, nbusy, lat;
        bit  held;
        logic [31:0] exp;
        exp = model(c, x, y);
        lat = model_lat(c, x, y);
        @(negedge clk);
        start = 1'b1; ctl = c; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0; nbusy = 0; held = 1'b1;
        while (!ready && n < 60) begin
            if (busy) nbusy++;
            if (result !== last_exp) held = 1'b0;
            if (n == poke) begin
                start = 1'b1; ctl = OPDIVU; a = 32'h1234_5678; b = 32'd7;
            end else begin
                start = 1'b0; a = ~x; b = y + 32'd1;
            end
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        chk({tag, ".latency"}, 32'(n), 32'(lat));
        chk({tag, ".busy_cycles"}, 32'(nbusy), 32'(lat));
        chk({tag, ".held_in_calc"}, {31'b0, held}, 32'd1);
        chk({tag, ".busy_in_done"}, {31'b0, busy}, 32'd0);
        chk({tag, ".result"}, result, exp);
        last_exp = exp;
        @(posedge clk); #1;
        chk({tag, ".ready_one_cycle"}, {31'b0, ready}, 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0]  codes [5];
        logic [4:0]  rc;
        logic [31:0] ra, rb;
        int          gone;
        codes = '{OPDIV, OPDIVU, OPREM, OPREMU, 5'd3};

        repeat (2) @(posedge clk);
        #1;
        chk("reset.busy", {31'b0, busy}, 32'd0);
        chk("reset.ready", {31'b0, ready}, 32'd0);
        chk("reset.result", result, 32'd0);
        @(negedge clk); rst = 1'b1;

        run_op("div_neg7_2", OPDIV, 32'hFFFF_FFF9, 32'd2, -1);
        run_op("remu_max_10", OPREMU, 32'hFFFF_FFFF, 32'd10, -1);
        run_op("divu_max_10", OPDIVU, 32'hFFFF_FFFF, 32'd10, -1);
        run_op("divu_by0", OPDIVU, 32'd100, 32'd0, -1);
        run_op("rem_by0", OPREM, 32'hFFFF_FFFB, 32'd0, -1);
        run_op("div_ovf", OPDIV, 32'h8000_0000, 32'hFFFF_FFFF, -1);
        run_op("rem_ovf", OPREM, 32'h8000_0000, 32'hFFFF_FFFF, -1);
        run_op("rem_3_7", OPREM, 32'd3, 32'd7, -1);
        run_op("bad_op", 5'd3, 32'd55, 32'd5, -1);
        run_op("rem_neg", OPREM, 32'hFFFF_FF9C, 32'd7, -1);
        run_op("start_mid_calc", OPDIV, 32'd1000, 32'd3, 5);

        // abort mid-operation with reset
        @(negedge clk);
        start = 1'b1; ctl = OPDIV; a = 32'd1000; b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        chk("abort.busy", {31'b0, busy}, 32'd0);
        chk("abort.result", result, 32'd0);
        chk("abort.ready", {31'b0, ready}, 32'd0);
        @(negedge clk); rst = 1'b1;
        last_exp = 32'd0;
        gone = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (ready || busy) gone++;
        end
        chk("abort.no_ready_after", 32'(gone), 32'd0);

        for (int k = 0; k < 40; k++) begin
            rc = codes[$urandom_range(0, 4)];
            ra = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = $urandom_range(1, 15);
                2: begin rb = 32'hFFFF_FFFF; ra = 32'h8000_0000; end
                3: rb = -$urandom_range(1, 15);
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) ra = $urandom_range(0, 20);
            run_op("random", rc, ra, rb, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
